decode_stage: RTL and testbench

//  RV64I instruction decode stage with ID/EX pipeline register. Accepts fetched

---
 rtl/decode_stage_pkg.sv | 45 ++++
 rtl/decode_stage_imm_gen.sv | 33 +++
 rtl/decode_stage.sv | 172 +++++++++++++++++
 tb/tb_decode_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared RV64I decode definitions: opcodes, jump encoding,
// immediate formats and the ID/EX control bundle.
package decode_stage_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_JAL  = 2'b01,
    JMP_JALR = 2'b10
  } jump_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_e;

  typedef struct packed {
    logic [2:0] funct3;
    logic       funct7b5;
    logic       alusrc;
    logic       memrd;
    logic       memwr;
    logic       branch;
    jump_e      jump;
    logic       word;
    logic       illegal;
    logic       regwr;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: selects the I/S/B/U/J
// field layout and sign-extends bit 31 to WORDSIZE.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [31:7]         i_instr,
  input  logic [2:0]          i_sel,
  output logic [WORDSIZE-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    unique case (imm_e'(i_sel))
      IMM_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25],
                        i_instr[11:7]};
      IMM_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_U: w_imm32 = {i_instr[31:12], 12'b0};
      IMM_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31],
                        i_instr[19:12], i_instr[20],
                        i_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign o_imm = {{(WORDSIZE-32){w_imm32[31]}}, w_imm32};

endmodule

// File: rtl/decode_stage.sv
// RV64I decode stage: control decode, operand capture, load-use
// stall and the ID/EX pipeline register with valid/ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int ADDRSIZE = 5,
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [31:0]         if_instr,
  input  logic [WORDSIZE-1:0] if_pc,
  output logic [ADDRSIZE-1:0] rs1,
  output logic [ADDRSIZE-1:0] rs2,
  input  logic [WORDSIZE-1:0] rs1data,
  input  logic [WORDSIZE-1:0] rs2data,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [WORDSIZE-1:0] ex_pc,
  output logic [WORDSIZE-1:0] ex_rs1data,
  output logic [WORDSIZE-1:0] ex_rs2data,
  output logic [WORDSIZE-1:0] ex_imm,
  output logic [ADDRSIZE-1:0] ex_rd,
  output logic                ex_regwr,
  output logic [2:0]          ex_funct3,
  output logic                ex_funct7b5,
  output logic                ex_alusrc,
  output logic                ex_memrd,
  output logic                ex_memwr,
  output logic                ex_branch,
  output logic [1:0]          ex_jump,
  output logic                ex_word,
  output logic                ex_illegal
);

  logic [6:0]          w_opcode;
  logic [ADDRSIZE-1:0] w_rd;
  logic [WORDSIZE-1:0] w_imm;
  logic [WORDSIZE-1:0] w_op1;
  logic [WORDSIZE-1:0] w_op2;
  imm_e                w_sel;
  ctrl_t               w_ctrl;
  logic                w_use1;
  logic                w_use2;
  logic                w_has_rd;
  logic                w_hazard;

  logic                r_valid;
  logic [WORDSIZE-1:0] r_pc;
  logic [WORDSIZE-1:0] r_rs1data;
  logic [WORDSIZE-1:0] r_rs2data;
  logic [WORDSIZE-1:0] r_imm;
  logic [ADDRSIZE-1:0] r_rd;
  ctrl_t               r_ctrl;

  assign w_opcode = if_instr[6:0];
  assign rs1      = if_instr[15 +: ADDRSIZE];
  assign rs2      = if_instr[20 +: ADDRSIZE];

  always_comb begin
    w_ctrl        = '0;
    w_ctrl.funct3 = if_instr[14:12];
    w_ctrl.jump   = JMP_NONE;
    w_sel         = IMM_NONE;
    w_use1        = 1'b0;
    w_use2        = 1'b0;
    w_has_rd      = 1'b0;
    unique case (w_opcode)
      OP_LOAD: begin
        w_sel = IMM_I; w_use1 = 1'b1; w_has_rd = 1'b1;
        w_ctrl.alusrc = 1'b1; w_ctrl.memrd = 1'b1;
      end
      OP_STORE: begin
        w_sel = IMM_S; w_use1 = 1'b1; w_use2 = 1'b1;
        w_ctrl.alusrc = 1'b1; w_ctrl.memwr = 1'b1;
      end
      OP_IMM, OP_IMM32: begin
        w_sel = IMM_I; w_use1 = 1'b1; w_has_rd = 1'b1;
        w_ctrl.alusrc = 1'b1;
        w_ctrl.word   = (w_opcode == OP_IMM32);
        // only SRAI/SRAIW carry a meaningful bit 30
        w_ctrl.funct7b5 = (if_instr[13:12] == 2'b01) & if_instr[30];
      end
      OP_OP, OP_OP32: begin
        w_use1 = 1'b1; w_use2 = 1'b1; w_has_rd = 1'b1;
        w_ctrl.word     = (w_opcode == OP_OP32);
        w_ctrl.funct7b5 = if_instr[30];
      end
      OP_BRANCH: begin
        w_sel = IMM_B; w_use1 = 1'b1; w_use2 = 1'b1;
        w_ctrl.branch = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_sel = IMM_U; w_has_rd = 1'b1;
        w_ctrl.alusrc = 1'b1;
      end
      OP_JAL: begin
        w_sel = IMM_J; w_has_rd = 1'b1;
        w_ctrl.jump = JMP_JAL;
      end
      OP_JALR: begin
        w_sel = IMM_I; w_use1 = 1'b1; w_has_rd = 1'b1;
        w_ctrl.alusrc = 1'b1; w_ctrl.jump = JMP_JALR;
      end
      default: w_ctrl.illegal = 1'b1;
    endcase
    w_rd         = w_has_rd ? if_instr[7 +: ADDRSIZE] : '0;
    w_ctrl.regwr = (w_rd != '0);
  end

  decode_stage_imm_gen #(
    .WORDSIZE(WORDSIZE)
  ) u_imm_gen (
    .i_instr(if_instr[31:7]),
    .i_sel  (w_sel),
    .o_imm  (w_imm)
  );

  assign w_op1 = (rs1 == '0) ? '0 : rs1data;
  assign w_op2 = (rs2 == '0) ? '0 : rs2data;

  assign w_hazard = r_valid & r_ctrl.memrd & (r_rd != '0) &
                    ((w_use1 & (rs1 == r_rd)) |
                     (w_use2 & (rs2 == r_rd)));

  assign if_ready = flush | ((~r_valid | ex_ready) & ~w_hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rs1data <= '0;
      r_rs2data <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (if_valid && if_ready) begin
      r_valid   <= 1'b1;
      r_pc      <= if_pc;
      r_rs1data <= w_op1;
      r_rs2data <= w_op2;
      r_imm     <= w_imm;
      r_rd      <= w_rd;
      r_ctrl    <= w_ctrl;
    end else if (ex_ready && (w_hazard || !if_valid)) begin
      r_valid <= 1'b0;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pc;
  assign ex_rs1data  = r_rs1data;
  assign ex_rs2data  = r_rs2data;
  assign ex_imm      = r_imm;
  assign ex_rd       = r_rd;
  assign ex_regwr    = r_ctrl.regwr;
  assign ex_funct3   = r_ctrl.funct3;
  assign ex_funct7b5 = r_ctrl.funct7b5;
  assign ex_alusrc   = r_ctrl.alusrc;
  assign ex_memrd    = r_ctrl.memrd;
  assign ex_memwr    = r_ctrl.memwr;
  assign ex_branch   = r_ctrl.branch;
  assign ex_jump     = r_ctrl.jump;
  assign ex_word     = r_ctrl.word;
  assign ex_illegal  = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, load-use stall,
// back-pressure, flush and asynchronous reset.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] rs1data;
  logic [63:0] rs2data;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_pc;
  logic [63:0] ex_rs1data;
  logic [63:0] ex_rs2data;
  logic [63:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_regwr;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_alusrc;
  logic        ex_memrd;
  logic        ex_memwr;
  logic        ex_branch;
  logic [1:0]  ex_jump;
  logic        ex_word;
  logic        ex_illegal;

  int errors = 0;
  int checks = 0;

  decode_stage #(.ADDRSIZE(5), .WORDSIZE(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .rs1(rs1), .rs2(rs2),
    .rs1data(rs1data), .rs2data(rs2data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_rs1data(ex_rs1data),
    .ex_rs2data(ex_rs2data), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_regwr(ex_regwr),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_alusrc(ex_alusrc), .ex_memrd(ex_memrd),
    .ex_memwr(ex_memwr), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_word(ex_word),
    .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rf(input logic [4:0] a);
    return 64'hA5A5_0000_0000_0000 | 64'(a);
  endfunction

  assign rs1data = rf(rs1);
  assign rs2data = rf(rs2);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADDI = 32'hFFF0_0293;
  localparam logic [31:0] I_LD   = 32'h0000_B183;
  localparam logic [31:0] I_ADD  = 32'h0021_8233;
  localparam logic [31:0] I_SUB  = 32'h4020_8333;
  localparam logic [31:0] I_BEQ  = 32'h0020_8863;
  localparam logic [31:0] I_SW   = 32'hFE71_2E23;
  localparam logic [31:0] I_JAL  = 32'hFFDF_F0EF;
  localparam logic [31:0] I_LUI  = 32'h8000_0537;
  localparam logic [31:0] I_BAD  = 32'h0000_007F;

  initial begin
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
    if_instr = 32'h0; if_pc = 64'h0; ex_ready = 1'b1;
    #2;
    chk("rst_valid", 64'(ex_valid), 64'd0);
    chk("rst_pc", ex_pc, 64'd0);
    chk("rst_imm", ex_imm, 64'd0);
    chk("rst_regwr", 64'(ex_regwr), 64'd0);
    chk("rst_ready", 64'(if_ready), 64'd1);
    #10;
    rst = 1'b1;

    drive(I_ADDI, 64'h100);
    chk("addi_ifready", 64'(if_ready), 64'd1);
    tick();
    chk("addi_valid", 64'(ex_valid), 64'd1);
    chk("addi_pc", ex_pc, 64'h100);
    chk("addi_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_rd", 64'(ex_rd), 64'd5);
    chk("addi_regwr", 64'(ex_regwr), 64'd1);
    chk("addi_alusrc", 64'(ex_alusrc), 64'd1);
    chk("addi_op1", ex_rs1data, 64'd0);

    drive(I_LD, 64'h104);
    tick();
    chk("ld_memrd", 64'(ex_memrd), 64'd1);
    chk("ld_rd", 64'(ex_rd), 64'd3);
    chk("ld_op1", ex_rs1data, rf(5'd1));
    chk("ld_funct3", 64'(ex_funct3), 64'd3);

    drive(I_ADD, 64'h108);
    chk("add_rs1", 64'(rs1), 64'd3);
    chk("hz_ifready", 64'(if_ready), 64'd0);
    tick();
    chk("hz_bubble", 64'(ex_valid), 64'd0);
    chk("hz_ifready_after", 64'(if_ready), 64'd1);
    tick();
    chk("add_valid", 64'(ex_valid), 64'd1);
    chk("add_pc", ex_pc, 64'h108);
    chk("add_rd", 64'(ex_rd), 64'd4);
    chk("add_op1", ex_rs1data, rf(5'd3));
    chk("add_op2", ex_rs2data, rf(5'd2));
    chk("add_alusrc", 64'(ex_alusrc), 64'd0);
    chk("add_f7", 64'(ex_funct7b5), 64'd0);

    ex_ready = 1'b0;
    drive(I_SUB, 64'h10C);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ifready", 64'(if_ready), 64'd0);
      tick();
      chk("bp_valid", 64'(ex_valid), 64'd1);
      chk("bp_pc", ex_pc, 64'h108);
      chk("bp_rd", 64'(ex_rd), 64'd4);
      chk("bp_op1", ex_rs1data, rf(5'd3));
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(if_ready), 64'd1);
    tick();
    chk("sub_pc", ex_pc, 64'h10C);
    chk("sub_f7", 64'(ex_funct7b5), 64'd1);
    chk("sub_rd", 64'(ex_rd), 64'd6);

    flush = 1'b1;
    drive(I_BEQ, 64'h110);
    chk("fl_ifready", 64'(if_ready), 64'd1);
    tick();
    chk("fl_valid", 64'(ex_valid), 64'd0);
    chk("fl_pc_kept", ex_pc, 64'h10C);
    flush = 1'b0;
    if_valid = 1'b0;
    tick();
    chk("fl_idle_valid", 64'(ex_valid), 64'd0);

    drive(I_SW, 64'h200);
    tick();
    chk("sw_memwr", 64'(ex_memwr), 64'd1);
    chk("sw_rd", 64'(ex_rd), 64'd0);
    chk("sw_regwr", 64'(ex_regwr), 64'd0);
    chk("sw_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sw_op2", ex_rs2data, rf(5'd7));

    drive(I_BEQ, 64'h204);
    tick();
    chk("beq_branch", 64'(ex_branch), 64'd1);
    chk("beq_imm", ex_imm, 64'd16);
    chk("beq_rd", 64'(ex_rd), 64'd0);

    drive(I_JAL, 64'h208);
    tick();
    chk("jal_jump", 64'(ex_jump), 64'd1);
    chk("jal_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jal_rd", 64'(ex_rd), 64'd1);
    chk("jal_regwr", 64'(ex_regwr), 64'd1);

    drive(I_BAD, 64'h20C);
    tick();
    chk("bad_illegal", 64'(ex_illegal), 64'd1);
    chk("bad_regwr", 64'(ex_regwr), 64'd0);
    chk("bad_memrd", 64'(ex_memrd), 64'd0);
    chk("bad_memwr", 64'(ex_memwr), 64'd0);

    drive(I_LUI, 64'h210);
    tick();
    chk("lui_imm", ex_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_rd", 64'(ex_rd), 64'd10);
    chk("lui_illegal", 64'(ex_illegal), 64'd0);
    chk("lui_valid", 64'(ex_valid), 64'd1);

    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(ex_valid), 64'd0);
    chk("arst_pc", ex_pc, 64'd0);
    chk("arst_rd", 64'(ex_rd), 64'd0);
    rst = 1'b1;
    if_valid = 1'b0;
    tick();
    chk("arst_idle", 64'(ex_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
